mpi_reg_master: RTL
===================

MPI_REG_MASTER -- requirements
Module: mpi_reg_master

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CPU_ADDR_WIDTH, 12, MPI address width.
- CPU_DATA_WIDTH, 32, MPI data width.
- RD_LAT, 2, cycles from cpu_rd pulse to sampling of cpu_data_out; legal range 1..15.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clks  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  CPU_ADDR_WIDTH  request address.
- req_wdata  in  CPU_DATA_WIDTH  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_wr  out  1  response type (echo of req_wr).
- rsp_rdata  out  CPU_DATA_WIDTH  read data; 0 for writes.
- cpu_wr  out  1  MPI write strobe.
- cpu_wr_addr  out  CPU_ADDR_WIDTH  MPI address (reads and writes).
- cpu_data_in  out  CPU_DATA_WIDTH  MPI write data.
- cpu_rd  out  1  MPI read strobe.
- cpu_data_out  in  CPU_DATA_WIDTH  MPI read data, registered by the slave.
- cnt_clr  in  1  synchronous clear of the transaction counters.
- wr_cnt  out  16  count of issued MPI writes.
- rd_cnt  out  16  count of issued MPI reads.

Function
REQ-003 The block SHALL be the MPI initiator: one outstanding transaction; all outputs registered.
REQ-004 FSM states SHALL be IDLE, WR, RD_WAIT, RSP; req_rdy=1 only in IDLE.
REQ-005 Accept = req_vld & req_rdy at edge T; the block SHALL latch req_wr, req_addr and req_wdata, then enter WR (write) or RD_WAIT (read).
REQ-006 Write: in cycle T+1 the block SHALL drive cpu_wr=1 for exactly one cycle, with cpu_wr_addr=req_addr and cpu_data_in=req_wdata; it enters RSP with rsp_vld=1 from cycle T+2.
REQ-007 Read: in cycle C=T+1 the block SHALL drive cpu_rd=1 for exactly one cycle with cpu_wr_addr=req_addr.
REQ-008 Read, continued: cpu_wr_addr SHALL be held stable through cycle C+RD_LAT; cpu_data_out is sampled at the edge ending cycle C+RD_LAT; rsp_vld=1 from cycle C+RD_LAT+1.
REQ-009 A down-counter (4 bit) loaded with RD_LAT-1 at the cpu_rd cycle SHALL time RD_WAIT; the sample occurs when the counter reaches 0.
REQ-010 RSP: rsp_vld, rsp_wr and rsp_rdata SHALL hold stable until rsp_vld & rsp_rdy; on that edge the block returns to IDLE, so req_rdy=1 in the following cycle.
REQ-011 For writes, rsp_rdata SHALL be 0.
REQ-012 Outside WR and the cpu_rd cycle, cpu_wr and cpu_rd SHALL be 0; cpu_wr_addr and cpu_data_in SHALL hold their last driven values (no toggling while idle).
REQ-013 Minimum spacing with rsp_rdy tied high: write 3 cycles per transaction, read RD_LAT+3.
REQ-014 wr_cnt and rd_cnt SHALL increment by 1 in the cycle after each cpu_wr or cpu_rd pulse, wrapping 0xFFFF -> 0x0000.
REQ-015 cnt_clr=1 SHALL zero both counters at the next edge; cnt_clr coincident with an increment yields 0 (clear wins).
REQ-016 req_vld while req_rdy=0 SHALL be ignored; the requester holds its request until accepted.
REQ-017 cpu_data_out SHALL be ignored outside the sample edge.

Reset
REQ-018 While reset=0 the block SHALL force: state IDLE, req_rdy=1, rsp_vld=0, rsp_wr=0, rsp_rdata=0, cpu_wr=0, cpu_rd=0, cpu_wr_addr=0, cpu_data_in=0, wr_cnt=0, rd_cnt=0, latency counter=0.
REQ-019 Reset asserted mid-transaction SHALL abort it: no strobe, no response afterwards; first accept possible on the first edge after release.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset: hold reset=0 for 5 cycles, then release -> all outputs at REQ-018 values; req_rdy=1.
- Write: write addr 0x006, data 0x0000_A5A5, accepted at T -> cpu_wr=1 only in T+1 with addr 0x006 and data 0x0000A5A5; rsp_vld=1 at T+2 with rsp_wr=1 and rsp_rdata=0; wr_cnt=1.
- Read: RD_LAT=2; slave model returns 0x2017_1208 for addr 0x000 -> cpu_rd single pulse at C; addr 0x000 stable C..C+2; rsp_rdata=0x20171208 and rsp_wr=0 at C+3; rd_cnt=1.
- Backpressure: rsp_rdy=0 for 5 cycles while a second req_vld is held -> rsp_vld/rsp_rdata constant, req_rdy=0, no strobe; second request accepted one cycle after the rsp handshake.
- Abort: reset=0 during RD_WAIT -> rsp_vld never asserted; after release a new read completes normally.
- Counters: 65536 writes -> wr_cnt wraps to 0; cnt_clr asserted coincident with a cpu_rd pulse -> rd_cnt=0 next cycle.

Source files
------------

// File: rtl/mpi_reg_master.sv
// MPI register initiator: turns one valid/ready request into a cpu_wr or cpu_rd strobe and a held response.
// Latency: write response 2 cycles after accept, read response RD_LAT+2; req_rdy stays low until the response handshakes.
module mpi_reg_master #(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int RD_LAT         = 2
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  input  logic [CPU_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic                      rsp_wr,
  output logic [CPU_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      cpu_wr,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  output logic                      cpu_rd,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
  input  logic                      cnt_clr,
  output logic [15:0]               wr_cnt,
  output logic [15:0]               rd_cnt
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RSP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_rdy     <= 1'b1;
      rsp_vld     <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld && req_rdy) begin
            req_rdy     <= 1'b0;
            cpu_wr_addr <= req_addr;
            if (req_wr) begin
              cpu_wr      <= 1'b1;
              cpu_data_in <= req_wdata;
              state       <= WR;
            end else begin
              cpu_rd <= 1'b1;
              state  <= RD_WAIT;
            end
          end
        end
        WR: begin
          cpu_wr    <= 1'b0;
          rsp_vld   <= 1'b1;
          rsp_wr    <= 1'b1;
          rsp_rdata <= '0;
          state     <= RSP;
        end
        RD_WAIT: begin
          // Counter is loaded as the strobe drops, so it hits 0 in cycle C+RD_LAT.
          if (cpu_rd) begin
            cpu_rd  <= 1'b0;
            lat_cnt <= LAT_LOAD;
          end else if (lat_cnt == 4'd0) begin
            rsp_vld   <= 1'b1;
            rsp_wr    <= 1'b0;
            rsp_rdata <= cpu_data_out;
            state     <= RSP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (cnt_clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (cpu_wr) wr_cnt <= wr_cnt + 16'd1;
      if (cpu_rd) rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule
